// File: rtl/fu_sequencer.sv
// Microcoded sequencer that steps an 8-slot program through an external
// combinational functional unit, writing each result back to operand A/B/C.
module fu_sequencer #(
    parameter int PROG_DEPTH = 8,
    parameter int W          = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   len,
    input  logic         prog_we,
    input  logic [2:0]   prog_addr,
    input  logic [7:0]   prog_data,
    input  logic         load_we,
    input  logic [1:0]   load_sel,
    input  logic [W-1:0] load_data,
    output logic [7:0]   fu_instr,
    output logic [W-1:0] fu_a,
    output logic [W-1:0] fu_b,
    output logic [W-1:0] fu_c,
    input  logic [W-1:0] fu_f,
    output logic [W-1:0] result,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [7:0]   r_prog [PROG_DEPTH];
    logic [2:0]   r_pc;
    logic [2:0]   r_last_pc;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_c;
    logic [W-1:0] r_result;
    logic [7:0]   r_fu_instr;
    logic         r_busy;
    logic         r_done;
    logic         r_err;

    logic [2:0]   w_next_pc;
    logic [2:0]   w_next_op;
    logic [3:0]   w_len_m1;
    logic [1:0]   w_dest;
    logic         w_len_ok;
    logic         w_last;
    logic         w_start_err;
    logic         w_idle;

    function automatic logic [7:0] f_onehot(input logic [2:0] op);
        f_onehot = 8'd1 << op;
    endfunction

    assign w_idle   = (r_state == S_IDLE);
    assign w_len_ok = (len != 4'd0) && (len <= 4'd8);
    assign w_len_m1 = len - 4'd1;
    assign w_last   = (r_pc == r_last_pc);
    assign w_dest   = r_prog[r_pc][4:3];

    // Next-state and next-pc decode
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_start_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_len_ok) begin
                        w_next_state = S_ISSUE;
                        w_next_pc    = 3'd0;
                    end else begin
                        w_start_err  = 1'b1;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ISSUE: w_next_state = S_WB;
            S_WB: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_ISSUE;
                    w_next_pc    = r_pc + 3'd1;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Opcode for the next slot; a slot written in the launch cycle is bypassed
    always_comb begin
        w_next_op = 3'd0;
        if (w_idle && prog_we && (prog_addr == w_next_pc)) begin
            w_next_op = prog_data[7:5];
        end else begin
            w_next_op = r_prog[w_next_pc][7:5];
        end
    end

    // Control state, pc and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= 3'd0;
            r_last_pc  <= 3'd0;
            r_fu_instr <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_next_pc;
            if (w_idle && start && w_len_ok) begin
                r_last_pc <= w_len_m1[2:0];
            end
            r_fu_instr <= ((w_next_state == S_ISSUE) || (w_next_state == S_WB)) ?
                          f_onehot(w_next_op) : 8'h00;
            r_busy     <= (w_next_state == S_ISSUE) || (w_next_state == S_WB);
            r_done     <= (w_next_state == S_DONE);
            r_err      <= w_start_err;
        end
    end

    // Program store, writable only while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                r_prog[i] <= 8'h00;
            end
        end else if (w_idle && prog_we) begin
            r_prog[prog_addr] <= prog_data;
        end
    end

    // Operand registers: host loads while idle, unit writeback in WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_result <= '0;
        end else if (w_idle && load_we) begin
            case (load_sel)
                2'b00:   r_a <= load_data;
                2'b01:   r_b <= load_data;
                2'b10:   r_c <= load_data;
                default: ;
            endcase
        end else if (r_state == S_WB) begin
            r_result <= fu_f;
            case (w_dest)
                2'b00:   r_a <= fu_f;
                2'b01:   r_b <= fu_f;
                2'b10:   r_c <= fu_f;
                default: ;
            endcase
        end
    end

    assign fu_instr = r_fu_instr;
    assign fu_a     = r_a;
    assign fu_b     = r_b;
    assign fu_c     = r_c;
    assign result   = r_result;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_fu_sequencer.sv
// Scoreboard bench for fu_sequencer: a reference FU drives fu_f, a register
// model predicts instructions/results, queues are drained as the DUT runs.
module tb_fu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       prog_we;
    logic [2:0] prog_addr;
    logic [7:0] prog_data;
    logic       load_we;
    logic [1:0] load_sel;
    logic [7:0] load_data;
    logic [7:0] fu_instr;
    logic [7:0] fu_a, fu_b, fu_c, fu_f, result;
    logic       busy, done, err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_reg  [3];
    logic [7:0] m_slot [8];
    logic [7:0] m_res;
    logic [7:0] instr_q [$];
    logic [7:0] res_q   [$];

    always #5 clk = ~clk;

    fu_sequencer #(.PROG_DEPTH(8), .W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .load_we(load_we), .load_sel(load_sel), .load_data(load_data),
        .fu_instr(fu_instr), .fu_a(fu_a), .fu_b(fu_b), .fu_c(fu_c),
        .fu_f(fu_f), .result(result), .busy(busy), .done(done), .err(err)
    );

    function automatic logic [7:0] fu_model(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] c);
        case (op)
            3'd0:    fu_model = a + c;
            3'd1:    fu_model = a - b;
            3'd2:    fu_model = a & c;
            3'd3:    fu_model = b | c;
            3'd4:    fu_model = a ^ b;
            3'd5:    fu_model = a + b;
            3'd6:    fu_model = ~a;
            3'd7:    fu_model = c - a;
            default: fu_model = 8'h00;
        endcase
    endfunction

    // Reference functional unit
    always_comb begin
        fu_f = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (fu_instr[i]) fu_f = fu_model(3'(i), fu_a, fu_b, fu_c);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_load(input logic [1:0] sel, input logic [7:0] data);
        load_we = 1'b1; load_sel = sel; load_data = data;
        @(posedge clk); #1;
        load_we = 1'b0;
        if (sel != 2'b11) m_reg[sel] = data;
    endtask

    task automatic do_prog(input logic [2:0] addr, input logic [7:0] data);
        prog_we = 1'b1; prog_addr = addr; prog_data = data;
        @(posedge clk); #1;
        prog_we = 1'b0;
        m_slot[addr] = data;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_A"}, fu_a, m_reg[0]);
        chk({tag, "_B"}, fu_b, m_reg[1]);
        chk({tag, "_C"}, fu_c, m_reg[2]);
        chk({tag, "_result"}, result, m_res);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_reg[i] = 8'h00;
        for (int i = 0; i < 8; i++) m_slot[i] = 8'h00;
        m_res = 8'h00;
    endtask

    // Launch an n-slot program; any load/prog strobes set by the caller share the start cycle
    task automatic run(input string tag, input int n, input bit mid_start, input bit poke);
        logic [2:0] op;
        logic [1:0] d;
        logic [7:0] f;
        for (int i = 0; i < n; i++) begin
            op = m_slot[i][7:5];
            d  = m_slot[i][4:3];
            f  = fu_model(op, m_reg[0], m_reg[1], m_reg[2]);
            instr_q.push_back(8'd1 << op);
            instr_q.push_back(8'd1 << op);
            res_q.push_back(f);
            if (d != 2'b11) m_reg[d] = f;
            m_res = f;
        end
        start = 1'b1; len = 4'(n);
        @(posedge clk); #1;
        start = 1'b0; load_we = 1'b0; prog_we = 1'b0;
        for (int k = 0; k <= 2 * n; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            start = mid_start && (k == 3);
            if (poke && k == 1) begin
                load_we = 1'b1; load_sel = 2'b00; load_data = 8'hEE;
                prog_we = 1'b1; prog_addr = 3'd0; prog_data = 8'hFF;
            end else begin
                load_we = 1'b0; prog_we = 1'b0;
            end
            if (k < 2 * n) begin
                chk({tag, "_busy"}, busy, 1);
                chk({tag, "_done_early"}, done, 0);
                chk({tag, "_instr"}, fu_instr, instr_q.pop_front());
            end else begin
                chk({tag, "_done"}, done, 1);
                chk({tag, "_busy_done"}, busy, 0);
                chk({tag, "_instr_done"}, fu_instr, 8'h00);
            end
            if (k >= 2 && (k % 2) == 0) chk({tag, "_wb_result"}, result, res_q.pop_front());
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_done"}, done, 0);
        check_regs(tag);
    endtask

    task automatic bad_len(input string tag, input logic [3:0] l);
        start = 1'b1; len = l;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_err"}, err, 1);
        chk({tag, "_busy"}, busy, 0);
        @(posedge clk); #1;
        chk({tag, "_err_clear"}, err, 0);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int seen_done;
        rst = 1'b1; start = 1'b0; len = 4'd0;
        prog_we = 1'b0; prog_addr = 3'd0; prog_data = 8'h00;
        load_we = 1'b0; load_sel = 2'b00; load_data = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr", fu_instr, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        check_regs("rst");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // single slot: A = A + C
        do_load(2'b00, 8'd3);
        do_load(2'b10, 8'd5);
        do_prog(3'd0, {3'd0, 2'b00, 3'b000});
        run("one", 1, 1'b0, 1'b0);

        // two slots, second consumes first's writeback
        do_load(2'b00, 8'h0F);
        do_load(2'b01, 8'hF0);
        do_load(2'b10, 8'h3C);
        do_prog(3'd0, {3'd3, 2'b10, 3'b000});
        do_prog(3'd1, {3'd2, 2'b01, 3'b000});
        run("two", 2, 1'b0, 1'b0);
        chk("two_C_fc", fu_c, 8'hFC);
        chk("two_B_0c", fu_b, 8'h0C);

        // illegal lengths
        bad_len("len0", 4'd0);
        bad_len("len9", 4'd9);
        check_regs("badlen");

        // full program, opcodes 7..0, with a stray start mid-run
        for (int i = 0; i < 8; i++) do_prog(3'(i), {3'(7 - i), 2'(i % 4), 3'b101});
        run("eight", 8, 1'b1, 1'b0);

        // writes while busy are ignored
        do_prog(3'd0, {3'd5, 2'b01, 3'b000});
        do_prog(3'd1, {3'd4, 2'b10, 3'b000});
        run("poke", 2, 1'b0, 1'b1);
        run("poke_slot", 1, 1'b0, 1'b0);

        // load and slot write in the start cycle are used by slot0
        load_we = 1'b1; load_sel = 2'b00; load_data = 8'h11; m_reg[0] = 8'h11;
        prog_we = 1'b1; prog_addr = 3'd0; prog_data = {3'd0, 2'b10, 3'b000};
        m_slot[0] = {3'd0, 2'b10, 3'b000};
        run("same", 1, 1'b0, 1'b0);

        // reset during WB of slot1 of a 3-slot program
        do_prog(3'd2, {3'd6, 2'b00, 3'b000});
        start = 1'b1; len = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_instr", fu_instr, 8'h00);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        model_reset();
        check_regs("abort");
        @(negedge clk); rst = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        chk("abort_no_resume", seen_done, 0);
        run("post_rst", 1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
